// File: rtl/ram_line_reader.sv
// rtl/ram_line_reader.sv - line-buffer RAM read controller emitting a valid/ready pixel stream
// Reads a run of consecutive words through a 1-cycle RAM port into a 2-entry skid buffer.
module ram_line_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int LEN_WIDTH     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] startAddr,
  input  logic [LEN_WIDTH-1:0]     length,
  output logic [ADDRESS_WIDTH-1:0] ramAddr,
  input  logic [DATA_WIDTH-1:0]    ramQ,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     doutValid,
  input  logic                     doutReady,
  output logic                     doutLast,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]            addr_q, addr_d;
  logic [LEN_WIDTH-1:0]                remaining_q, remaining_d;
  logic                                inflight_q, inflight_d;
  logic                                inflight_last_q, inflight_last_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic [1:0][DATA_WIDTH-1:0]          buf_data_q, buf_data_d;
  logic [1:0]                          buf_last_q, buf_last_d;
  logic                                rd_ptr_q, rd_ptr_d;
  logic                                wr_ptr_q, wr_ptr_d;
  logic [1:0]                          count_q, count_d;

  logic                                pop;
  logic                                push;
  logic                                head_last;
  logic [2:0]                          occupancy;
  logic                                issue;

  assign pop       = (count_q != 2'd0) && doutReady;
  assign push      = inflight_q;
  assign head_last = buf_last_q[rd_ptr_q];

  // Entries already held plus the word still coming back from RAM, less the one leaving now.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == S_READ) && (occupancy < 3'd2);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    buf_data_d      = buf_data_q;
    buf_last_d      = buf_last_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q + {1'b0, push} - {1'b0, pop};
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == LEN_WIDTH'(1));

    if (push) begin
      buf_data_d[wr_ptr_q] = ramQ;
      buf_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_READ;
            addr_d      = startAddr;
            remaining_d = length;
            busy_d      = 1'b1;
          end
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d      = addr_q + ADDRESS_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      buf_data_q      <= '0;
      buf_last_q      <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      buf_data_q      <= buf_data_d;
      buf_last_q      <= buf_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end

  // The address register doubles as the RAM port address; it only moves when a read issues.
  assign ramAddr   = addr_q;
  assign dout      = buf_data_q[rd_ptr_q];
  assign doutValid = (count_q != 2'd0);
  assign doutLast  = doutValid && head_last;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
